// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage external SRAM controller.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memState_t;

  localparam int DEFAULT_BASE_ADDR = 1024;
  localparam int WORD_BYTES        = 4;

  // Counter width helper: a one-value counter still needs a 1-bit register.
  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// CPU-side MEM-stage request bus between the pipeline and the SRAM controller.
interface sram_mem_ctrl_if #(
  parameter int WORD_W = 32
);

  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_mem_ctrl_beat_counter.sv
// Wait-cycle and beat counters for one SRAM access; also exposes next values
// so the controller can register its SRAM pins one cycle ahead.
module sram_mem_ctrl_beat_counter
  import sram_mem_ctrl_pkg::*;
#(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 5,
  parameter int BEAT_CW     = clog2Min1(BEATS),
  parameter int WAIT_CW     = clog2Min1(WAIT_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [WAIT_CW-1:0] waitCnt,
  output logic [WAIT_CW-1:0] waitNext,
  output logic [BEAT_CW-1:0] beatCnt,
  output logic [BEAT_CW-1:0] beatNext,
  output logic               lastWait,
  output logic               lastBeat
);

  assign lastWait = (waitCnt == WAIT_CW'(WAIT_CYCLES - 1));
  assign lastBeat = (beatCnt == BEAT_CW'(BEATS - 1));

  // Outside an access both counters sit at zero, ready for the next start.
  always_comb begin
    waitNext = '0;
    beatNext = '0;
    if (enable) begin
      if (lastWait) begin
        waitNext = '0;
        beatNext = lastBeat ? '0 : beatCnt + BEAT_CW'(1);
      end else begin
        waitNext = waitCnt + WAIT_CW'(1);
        beatNext = beatCnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      beatCnt <= '0;
    end else begin
      waitCnt <= waitNext;
      beatCnt <= beatNext;
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage external SRAM controller: splits each CPU word into little-endian
// SRAM beats of WAIT_CYCLES cycles each and stalls the pipeline via ready.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int SRAM_DW     = 16,
  parameter int WORD_W      = 8 * WORD_BYTES,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     cpu,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int BEATS      = WORD_W / SRAM_DW;
  localparam int BEAT_CW    = clog2Min1(BEATS);
  localparam int WAIT_CW    = clog2Min1(WAIT_CYCLES);
  localparam int BYTE_SHIFT = $clog2(WORD_W / 8);
  localparam int BEAT_SHIFT = $clog2(BEATS);
  localparam int IDX_W      = ADDR_W - BEAT_SHIFT;

  memState_t          state;
  memState_t          stateNext;
  logic               opWrite;
  logic [IDX_W-1:0]   idxReg;
  logic [WORD_W-1:0]  wordReg;

  logic [WAIT_CW-1:0] waitCnt;
  logic [WAIT_CW-1:0] waitNext;
  logic [BEAT_CW-1:0] beatCnt;
  logic [BEAT_CW-1:0] beatNext;
  logic               lastWait;
  logic               lastBeat;

  logic               req;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idxLive;
  logic               accessNext;
  logic               opWriteNext;
  logic               lastWaitNext;
  logic [IDX_W-1:0]   idxNext;
  logic [WORD_W-1:0]  wordNext;
  logic [ADDR_W-1:0]  addrNext;
  logic [SRAM_DW-1:0] wdataNext;
  logic               captureEn;

  logic [SRAM_DW-1:0] wordSlices [BEATS];
  logic [SRAM_DW-1:0] readBeats  [BEATS];

  sram_mem_ctrl_beat_counter #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEAT_CW     (BEAT_CW),
    .WAIT_CW     (WAIT_CW)
  ) beatCounter (
    .clk      (clk),
    .rst      (rst),
    .enable   (state == ACCESS),
    .waitCnt  (waitCnt),
    .waitNext (waitNext),
    .beatCnt  (beatCnt),
    .beatNext (beatNext),
    .lastWait (lastWait),
    .lastBeat (lastBeat)
  );

  assign req       = cpu.rd_en | cpu.wr_en;
  assign offset    = cpu.address - 32'(BASE_ADDR);
  assign idxLive   = IDX_W'(offset >> BYTE_SHIFT);
  assign cpu.ready = ((state == IDLE) && !req) || (state == DONE);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = ACCESS;
      ACCESS:  if (lastWait && lastBeat) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request fields are latched on leaving IDLE so a dropped request still completes.
  assign accessNext   = (stateNext == ACCESS);
  assign opWriteNext  = (state == IDLE) ? cpu.wr_en      : opWrite;
  assign idxNext      = (state == IDLE) ? idxLive        : idxReg;
  assign wordNext     = (state == IDLE) ? cpu.write_data : wordReg;
  assign lastWaitNext = (waitNext == WAIT_CW'(WAIT_CYCLES - 1));
  assign addrNext     = ADDR_W'(idxNext) * ADDR_W'(BEATS) + ADDR_W'(beatNext);

  for (genvar gi = 0; gi < BEATS; gi++) begin : gWordSlice
    assign wordSlices[gi] = wordNext[gi*SRAM_DW +: SRAM_DW];
  end

  always_comb begin
    wdataNext = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beatNext == BEAT_CW'(i)) wdataNext = wordSlices[i];
    end
  end

  // SRAM pins are registered from next-cycle state, so they change with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      opWrite    <= 1'b0;
      idxReg     <= '0;
      wordReg    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      state     <= stateNext;
      opWrite   <= opWriteNext;
      idxReg    <= idxNext;
      wordReg   <= wordNext;
      sram_oe_n <= !(accessNext && !opWriteNext);
      sram_we_n <= !(accessNext && opWriteNext && !lastWaitNext);
      if (accessNext) sram_addr <= addrNext;
      if (accessNext && opWriteNext) sram_wdata <= wdataNext;
    end
  end

  assign captureEn = (state == ACCESS) && !opWrite && lastWait;

  for (genvar gi = 0; gi < BEATS; gi++) begin : gReadBeat
    always_ff @(posedge clk) begin
      if (rst) begin
        readBeats[gi] <= '0;
      end else if (captureEn && (beatCnt == BEAT_CW'(gi))) begin
        readBeats[gi] <= sram_rdata;
      end
    end
    assign cpu.read_data[gi*SRAM_DW +: SRAM_DW] = readBeats[gi];
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: default 16-bit/5-wait instance plus a
// 32-bit/1-wait instance, each with a behavioural SRAM.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFails   = 0;

  sram_mem_ctrl_if #(.WORD_W(32)) ifA ();
  sram_mem_ctrl_if #(.WORD_W(32)) ifB ();

  logic [17:0] addrA;
  logic [15:0] wdataA;
  logic [15:0] rdataA;
  logic        weA;
  logic        oeA;
  logic [17:0] addrB;
  logic [31:0] wdataB;
  logic [31:0] rdataB;
  logic        weB;
  logic        oeB;

  sram_mem_ctrl dutA (
    .clk        (clk),
    .rst        (rst),
    .cpu        (ifA.slave),
    .sram_addr  (addrA),
    .sram_wdata (wdataA),
    .sram_rdata (rdataA),
    .sram_we_n  (weA),
    .sram_oe_n  (oeA)
  );

  sram_mem_ctrl #(.SRAM_DW(32), .WAIT_CYCLES(1)) dutB (
    .clk        (clk),
    .rst        (rst),
    .cpu        (ifB.slave),
    .sram_addr  (addrB),
    .sram_wdata (wdataB),
    .sram_rdata (rdataB),
    .sram_we_n  (weB),
    .sram_oe_n  (oeB)
  );

  logic [15:0] memA [0:262143];
  logic [31:0] memB [0:262143];

  always @(posedge clk) begin
    if (!weA) memA[addrA] <= wdataA;
  end
  assign rdataA = memA[addrA];

  always @(posedge clk) begin
    if (rst) begin
      memB[0] <= 32'hA5A5_0001;
      memB[1] <= 32'h0BAD_F00D;
    end else if (!weB) begin
      memB[addrB] <= wdataB;
    end
  end
  assign rdataB = memB[addrB];

  logic        traceWe   [0:15];
  logic        traceOe   [0:15];
  logic [17:0] traceAddr [0:15];
  logic [15:0] traceWd   [0:15];

  int          low;
  logic [31:0] rdv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request on A at a negedge, count ready-low cycles, trace SRAM pins.
  task automatic accessA(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, output int lowCnt, output logic [31:0] rdAtDone);
    ifA.wr_en      = wr;
    ifA.rd_en      = rd;
    ifA.address    = addr;
    ifA.write_data = data;
    lowCnt   = 0;
    rdAtDone = '0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (ifA.ready === 1'b1) begin
        rdAtDone = ifA.read_data;
        break;
      end
      if (lowCnt < 16) begin
        traceWe[lowCnt]   = weA;
        traceOe[lowCnt]   = oeA;
        traceAddr[lowCnt] = addrA;
        traceWd[lowCnt]   = wdataA;
      end
      lowCnt++;
      @(negedge clk);
    end
    ifA.wr_en = 1'b0;
    ifA.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic readB(input logic [31:0] addr, input logic release_req,
                       output int lowCnt, output logic [31:0] rdAtDone);
    ifB.wr_en   = 1'b0;
    ifB.rd_en   = 1'b1;
    ifB.address = addr;
    lowCnt   = 0;
    rdAtDone = '0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (ifB.ready === 1'b1) begin
        rdAtDone = ifB.read_data;
        break;
      end
      lowCnt++;
      @(negedge clk);
    end
    if (release_req) ifB.rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ifA.wr_en = 1'b0; ifA.rd_en = 1'b0; ifA.address = '0; ifA.write_data = '0;
    ifB.wr_en = 1'b0; ifB.rd_en = 1'b0; ifB.address = '0; ifB.write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready",   64'(ifA.ready),     64'd1);
    check("reset_we_n",    64'(weA),           64'd1);
    check("reset_oe_n",    64'(oeA),           64'd1);
    check("reset_addr",    64'(addrA),         64'd0);
    check("reset_wdata",   64'(wdataA),        64'd0);
    check("reset_rdata",   64'(ifA.read_data), 64'd0);
    check("reset_readyB",  64'(ifB.ready),     64'd1);
    rst = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("idle_ready", 64'(ifA.ready), 64'd1);
      check("idle_we_n",  64'(weA),       64'd1);
      check("idle_oe_n",  64'(oeA),       64'd1);
    end
    @(negedge clk);

    accessA(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, low, rdv);
    $display("write A addr=1028 data=0xdeadbeef low=%0d", low);
    check("wr_low_cycles", 64'(low),          64'd11);
    check("wr_idle_we_n",  64'(traceWe[0]),   64'd1);
    check("wr_b0_addr",    64'(traceAddr[1]), 64'd2);
    check("wr_b0_wdata",   64'(traceWd[1]),   64'h BEEF);
    check("wr_b0_we_c1",   64'(traceWe[1]),   64'd0);
    check("wr_b0_we_c4",   64'(traceWe[4]),   64'd0);
    check("wr_b0_we_c5",   64'(traceWe[5]),   64'd1);
    check("wr_b1_addr",    64'(traceAddr[6]), 64'd3);
    check("wr_b1_wdata",   64'(traceWd[6]),   64'h DEAD);
    check("wr_b1_we_c6",   64'(traceWe[6]),   64'd0);
    check("wr_b1_we_c10",  64'(traceWe[10]),  64'd1);
    check("wr_oe_n",       64'(traceOe[3]),   64'd1);
    check("wr_after_we_n", 64'(weA),          64'd1);

    accessA(1'b0, 1'b1, 32'd1028, 32'h0, low, rdv);
    $display("read A addr=1028 data=0x%08h low=%0d", rdv, low);
    check("rd_low_cycles", 64'(low),           64'd11);
    check("rd_data",       64'(rdv),           64'h DEAD_BEEF);
    check("rd_oe_n",       64'(traceOe[1]),    64'd0);
    check("rd_we_n",       64'(traceWe[1]),    64'd1);
    check("rd_b1_addr",    64'(traceAddr[10]), 64'd3);

    accessA(1'b1, 1'b1, 32'd1032, 32'h1234_5678, low, rdv);
    $display("rd+wr A addr=1032 data=0x12345678 low=%0d", low);
    check("both_low_cycles", 64'(low),          64'd11);
    check("both_rdata_kept", 64'(rdv),          64'h DEAD_BEEF);
    check("both_we_n",       64'(traceWe[1]),   64'd0);
    check("both_oe_n",       64'(traceOe[1]),   64'd1);
    check("both_addr",       64'(traceAddr[1]), 64'd4);
    check("both_b1_wdata",   64'(traceWd[6]),   64'h 1234);

    accessA(1'b0, 1'b1, 32'd1032, 32'h0, low, rdv);
    $display("read A addr=1032 data=0x%08h low=%0d", rdv, low);
    check("rd2_data", 64'(rdv), 64'h 1234_5678);

    ifA.wr_en = 1'b1; ifA.address = 32'd1036; ifA.write_data = 32'hCAFE_F00D;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_pre_we_n", 64'(weA),   64'd0);
    check("midrst_pre_addr", 64'(addrA), 64'd6);
    rst = 1'b1;
    @(negedge clk); #1;
    $display("reset mid-write A addr=1036 we_n=%0b ready=%0b", weA, ifA.ready);
    check("midrst_we_n",  64'(weA),           64'd1);
    check("midrst_oe_n",  64'(oeA),           64'd1);
    check("midrst_rdata", 64'(ifA.read_data), 64'd0);
    check("midrst_addr",  64'(addrA),         64'd0);
    check("midrst_wdata", 64'(wdataA),        64'd0);
    check("midrst_ready_req", 64'(ifA.ready), 64'd0);
    ifA.wr_en = 1'b0;
    #1;
    check("midrst_ready_idle", 64'(ifA.ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    accessA(1'b0, 1'b1, 32'd1028, 32'h0, low, rdv);
    $display("read A after reset addr=1028 data=0x%08h low=%0d", rdv, low);
    check("post_rst_low",  64'(low), 64'd11);
    check("post_rst_data", 64'(rdv), 64'h DEAD_BEEF);

    readB(32'd1024, 1'b0, low, rdv);
    $display("read B addr=1024 data=0x%08h low=%0d", rdv, low);
    check("b_rd1_low",  64'(low), 64'd2);
    check("b_rd1_data", 64'(rdv), 64'h A5A5_0001);
    readB(32'd1024, 1'b1, low, rdv);
    $display("read B back-to-back addr=1024 data=0x%08h low=%0d", rdv, low);
    check("b_rd2_low",  64'(low), 64'd2);
    check("b_rd2_data", 64'(rdv), 64'h A5A5_0001);
    readB(32'd1028, 1'b1, low, rdv);
    $display("read B addr=1028 data=0x%08h low=%0d", rdv, low);
    check("b_rd3_low",  64'(low), 64'd2);
    check("b_rd3_data", 64'(rdv), 64'h 0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
